// File: rtl/alarm_beep_scheduler.sv
// Shares one buzzer between four alarm sources with per-source on/off cadence,
// strict index priority with preemption, and a timed operator mute.
module alarm_beep_scheduler #(
  parameter int unsigned TICK_DIV = 50_000,
  parameter int unsigned MUTE_MS  = 10_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] alarm_req,
  input  logic       mute_pulse,
  output logic       beep,
  output logic [1:0] active_src,
  output logic       alarm_active,
  output logic       muted
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_MUTED} state_t;

  state_t        state_q, state_d;
  logic [1:0]    src_q, src_d;
  logic [3:0]    mute_set_q, mute_set_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   ms_q, ms_d;
  logic          beep_q, beep_d;

  logic          restart;
  logic          tick;
  logic [3:0]    unmasked;
  logic [3:0]    fresh;
  logic          preempt;

  function automatic logic [1:0] winner(input logic [3:0] r);
    logic [1:0] w;
    w = 2'd0;
    if (r[3])      w = 2'd3;
    else if (r[2]) w = 2'd2;
    else if (r[1]) w = 2'd1;
    return w;
  endfunction

  function automatic logic [3:0] above_mask(input logic [1:0] s);
    logic [3:0] m;
    case (s)
      2'd0:    m = 4'b1110;
      2'd1:    m = 4'b1100;
      2'd2:    m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [15:0] on_ms(input logic [1:0] s);
    logic [15:0] d;
    case (s)
      2'd0:    d = 16'd200;
      2'd1:    d = 16'd200;
      2'd2:    d = 16'd100;
      default: d = 16'hFFFF;
    endcase
    return d;
  endfunction

  // src3 has no OFF phase of its own; its drop-out uses the src2 gap.
  function automatic logic [15:0] off_ms(input logic [1:0] s);
    logic [15:0] d;
    case (s)
      2'd0:    d = 16'd800;
      2'd1:    d = 16'd300;
      default: d = 16'd100;
    endcase
    return d;
  endfunction

  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign unmasked = alarm_req & ~mute_set_q;
  assign fresh    = alarm_req & ~mute_set_q;
  assign preempt  = |(unmasked & above_mask(src_q));

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    mute_set_d = mute_set_q;
    restart    = 1'b0;
    case (state_q)
      S_IDLE: begin
        restart = 1'b1;
        if (|unmasked) begin
          state_d = S_ON;
          src_d   = winner(unmasked);
        end
      end
      S_ON, S_OFF: begin
        // Precedence: mute, then preemption, then phase expiry.
        if (mute_pulse) begin
          state_d    = S_MUTED;
          mute_set_d = alarm_req;
          restart    = 1'b1;
        end else if (preempt) begin
          state_d = S_ON;
          src_d   = winner(unmasked);
          restart = 1'b1;
        end else if (state_q == S_ON) begin
          if (src_q == 2'd3) begin
            if (!unmasked[3]) begin
              state_d = S_OFF;
              restart = 1'b1;
            end
          end else if (tick && (ms_q == on_ms(src_q) - 16'd1)) begin
            state_d = S_OFF;
            restart = 1'b1;
          end
        end else if (tick && (ms_q == off_ms(src_q) - 16'd1)) begin
          restart = 1'b1;
          if (|unmasked) begin
            state_d = S_ON;
            src_d   = winner(unmasked);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_MUTED: begin
        mute_set_d = mute_set_q & alarm_req;
        if (|fresh) begin
          state_d    = S_ON;
          src_d      = winner(fresh);
          mute_set_d = 4'b0000;
          restart    = 1'b1;
        end else if (tick && (ms_q == 16'(MUTE_MS) - 16'd1)) begin
          state_d    = S_IDLE;
          mute_set_d = 4'b0000;
          restart    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        restart = 1'b1;
      end
    endcase

    if (restart) begin
      presc_d = '0;
      ms_d    = 16'd0;
    end else if (tick) begin
      presc_d = '0;
      ms_d    = (ms_q == 16'hFFFF) ? ms_q : ms_q + 16'd1;
    end else begin
      presc_d = presc_q + PW'(1);
      ms_d    = ms_q;
    end

    beep_d = (state_d == S_ON);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_q      <= 2'd0;
      mute_set_q <= 4'b0000;
      presc_q    <= '0;
      ms_q       <= 16'd0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      mute_set_q <= mute_set_d;
      presc_q    <= presc_d;
      ms_q       <= ms_d;
      beep_q     <= beep_d;
    end
  end

  assign beep         = beep_q;
  assign active_src   = src_q;
  assign alarm_active = (state_q == S_ON) || (state_q == S_OFF);
  assign muted        = (state_q == S_MUTED);

endmodule

// File: tb/tb_alarm_beep_scheduler.sv
// Directed bench for alarm_beep_scheduler: 1 ms = 10 clk, mute shortened to 500 ms.
module tb_alarm_beep_scheduler;

  localparam int unsigned TD = 10;
  localparam int unsigned MM = 500;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] alarm_req = 4'b0000;
  logic       mute_pulse = 1'b0;
  logic       beep;
  logic [1:0] active_src;
  logic       alarm_active;
  logic       muted;

  int total = 0;
  int bad   = 0;

  alarm_beep_scheduler #(.TICK_DIV(TD), .MUTE_MS(MM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alarm_req    (alarm_req),
    .mute_pulse   (mute_pulse),
    .beep         (beep),
    .active_src   (active_src),
    .alarm_active (alarm_active),
    .muted        (muted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Checks beep holds v on n consecutive samples, ending on the sample after.
  task automatic run(input string tag, input logic v, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      if (beep !== v) errs++;
      step(1);
    end
    chk(tag, errs, 0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    alarm_req  = 4'b0000;
    mute_pulse = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    do_reset();
    chk("rst_beep", beep, 0);
    chk("rst_src", active_src, 0);
    chk("rst_active", alarm_active, 0);
    chk("rst_muted", muted, 0);

    // src0 cadence 200/800 ms
    alarm_req = 4'b0001;
    step(1);
    chk("t1_beep_on", beep, 1);
    chk("t1_src", active_src, 0);
    chk("t1_active", alarm_active, 1);
    run("t1_on_2000", 1'b1, 2000);
    run("t1_off_8000", 1'b0, 8000);
    chk("t1_repeat", beep, 1);

    // preemption by src2 500 clk into src0 ON
    do_reset();
    alarm_req = 4'b0001;
    step(1);
    run("t2_pre_on", 1'b1, 500);
    alarm_req = 4'b0101;
    step(1);
    chk("t2_beep", beep, 1);
    chk("t2_src", active_src, 2);
    run("t2_on_1000", 1'b1, 1000);
    run("t2_off_1000", 1'b0, 1000);
    chk("t2_rearm_beep", beep, 1);
    chk("t2_rearm_src", active_src, 2);

    // src2 drops: pair completes, then src0 cadence
    alarm_req = 4'b0001;
    run("t3_on_1000", 1'b1, 1000);
    run("t3_off_1000", 1'b0, 1000);
    chk("t3_src0_beep", beep, 1);
    chk("t3_src0_src", active_src, 0);
    run("t3_src0_on", 1'b1, 2000);
    chk("t3_src0_off", beep, 0);

    // src3 continuous, drop -> OFF 100 ms -> IDLE
    do_reset();
    alarm_req = 4'b1000;
    step(1);
    chk("t4_src", active_src, 3);
    run("t4_const", 1'b1, 5000);
    chk("t4_still", beep, 1);
    alarm_req = 4'b0000;
    step(1);
    chk("t4_drop_beep", beep, 0);
    chk("t4_drop_active", alarm_active, 1);
    step(999);
    chk("t4_off_end", alarm_active, 1);
    step(1);
    chk("t4_idle", alarm_active, 0);

    // mute src1, new src3 breaks mute
    do_reset();
    alarm_req = 4'b0010;
    step(1);
    chk("t5_src1", active_src, 1);
    mute_pulse = 1'b1;
    step(1);
    mute_pulse = 1'b0;
    chk("t5_mute_beep", beep, 0);
    chk("t5_muted", muted, 1);
    step(2000);
    chk("t5_hold", muted, 1);
    alarm_req = 4'b1010;
    step(1);
    chk("t5_unmute", muted, 0);
    chk("t5_beep", beep, 1);
    chk("t5_src3", active_src, 3);

    // mute timeout, ignored second pulse, re-arbitration, async reset
    do_reset();
    alarm_req = 4'b0001;
    step(1);
    mute_pulse = 1'b1;
    step(1);
    mute_pulse = 1'b0;
    chk("t6_muted", muted, 1);
    step(1999);
    mute_pulse = 1'b1;
    step(1);
    mute_pulse = 1'b0;
    step(2999);
    chk("t6_last_muted", muted, 1);
    step(1);
    chk("t6_expired", muted, 0);
    chk("t6_idle", alarm_active, 0);
    chk("t6_idle_beep", beep, 0);
    step(1);
    chk("t6_rebeep", beep, 1);
    chk("t6_src", active_src, 0);
    step(20);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_beep", beep, 0);
    chk("t6_rst_active", alarm_active, 0);
    chk("t6_rst_muted", muted, 0);
    chk("t6_rst_src", active_src, 0);

    // mute and new req in the same clk: new req is masked until it re-rises
    do_reset();
    alarm_req = 4'b0001;
    step(1);
    alarm_req  = 4'b0101;
    mute_pulse = 1'b1;
    step(1);
    mute_pulse = 1'b0;
    chk("t7_muted", muted, 1);
    step(10);
    chk("t7_masked", muted, 1);
    alarm_req = 4'b0001;
    step(1);
    chk("t7_drop", muted, 1);
    alarm_req = 4'b0101;
    step(1);
    chk("t7_unmute", muted, 0);
    chk("t7_src2", active_src, 2);
    chk("t7_beep", beep, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
